// File: rtl/rsp_ingress_queue.sv
// rsp_ingress_queue: per-initiator FIFO that stores pre-decoded onehot destinations
// and presents the head entry as a request to the rsp switch arbiter.
module rsp_ingress_queue #(
   parameter int NT    = 3,
   parameter int DW    = 32,
   parameter int DEPTH = 4,
   parameter int DSTW  = 2
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       in_vld,
   output logic                       in_rdy,
   input  logic [DSTW-1:0]            in_dst,
   input  logic [DW-1:0]              in_data,
   output logic [NT-1:0]              req,
   input  logic [NT-1:0]              vreq,
   output logic [DW-1:0]              out_data,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       err,
   output logic [7:0]                 err_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [NT+DW-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic             err_q, err_d;
   logic [7:0]       err_cnt_q, err_cnt_d;
   logic [NT+DW-1:0] head;
   logic             full, empty, acc, legal, push, drop, pop;

   always_comb begin
      full      = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
      empty     = wr_ptr_q == rd_ptr_q;
      head      = mem_q[rd_ptr_q[AW-1:0]];
      in_rdy    = !full;
      req       = empty ? '0 : head[DW+:NT];
      out_data  = empty ? '0 : head[DW-1:0];
      level     = wr_ptr_q - rd_ptr_q;
      acc       = in_vld && in_rdy;
      legal     = 32'(in_dst) < NT;
      push      = acc && legal;
      drop      = acc && !legal;
      pop       = |(req & vreq);
      wr_ptr_d  = wr_ptr_q + PW'(push);
      rd_ptr_d  = rd_ptr_q + PW'(pop);
      err_d     = drop;
      err_cnt_d = (drop && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
      err       = err_q;
      err_cnt   = err_cnt_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   // Payload storage needs no reset: empty masks stale entries from req/out_data.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= {NT'(1) << in_dst, in_data};
   end

`ifndef SYNTHESIS
   a_req_onehot0: assert property (@(posedge clk) disable iff (!rstn) $onehot0(req));
   a_no_pop_empty: assert property (@(posedge clk) disable iff (!rstn) !(pop && empty));
   a_level_max: assert property (@(posedge clk) disable iff (!rstn) level <= PW'(DEPTH));
`endif
endmodule

// File: tb/tb_rsp_ingress_queue.sv
// tb_rsp_ingress_queue: directed stimulus against a queue-based reference model,
// checked every cycle plus hand-computed literal expectations.
module tb_rsp_ingress_queue;
   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        in_vld = 1'b0;
   logic        in_rdy;
   logic [1:0]  in_dst = '0;
   logic [31:0] in_data = '0;
   logic [2:0]  req;
   logic [2:0]  vreq = '0;
   logic [31:0] out_data;
   logic [2:0]  level;
   logic        err;
   logic [7:0]  err_cnt;

   int checks = 0;
   int errors = 0;
   bit run_cmp = 1'b0;

   typedef struct packed {
      logic [2:0]  oh;
      logic [31:0] d;
   } ent_t;
   ent_t       mq[$];
   logic       m_err = 1'b0;
   logic [7:0] m_cnt = '0;

   rsp_ingress_queue #(.NT(3), .DW(32), .DEPTH(4), .DSTW(2)) dut (
      .clk(clk), .rstn(rstn), .in_vld(in_vld), .in_rdy(in_rdy), .in_dst(in_dst),
      .in_data(in_data), .req(req), .vreq(vreq), .out_data(out_data),
      .level(level), .err(err), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h at %0t", n, a, e, $time);
      end
   endtask

   // Reference model: a bounded queue of decoded entries updated on each clock edge.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mq.delete();
         m_err <= 1'b0;
         m_cnt <= '0;
      end else begin
         logic [2:0] h;
         logic       rdy, acc;
         h   = (mq.size() != 0) ? mq[0].oh : 3'b000;
         rdy = mq.size() < 4;
         acc = in_vld && rdy;
         if ((h & vreq) != 3'b000) void'(mq.pop_front());
         if (acc && in_dst < 2'd3) mq.push_back({3'b001 << in_dst, in_data});
         m_err <= acc && in_dst == 2'd3;
         if (acc && in_dst == 2'd3 && m_cnt != 8'hFF) m_cnt <= m_cnt + 8'd1;
      end
   end

   always @(negedge clk) begin
      if (run_cmp) begin
         chk("m_in_rdy", 64'(in_rdy), 64'(mq.size() < 4));
         chk("m_req", 64'(req), 64'((mq.size() != 0) ? mq[0].oh : 3'b000));
         chk("m_out_data", 64'(out_data), 64'((mq.size() != 0) ? mq[0].d : 32'h0));
         chk("m_level", 64'(level), 64'(mq.size()));
         chk("m_err", 64'(err), 64'(m_err));
         chk("m_err_cnt", 64'(err_cnt), 64'(m_cnt));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) tick();
      rstn = 1'b1;
      run_cmp = 1'b1;
      chk("rst_in_rdy", 64'(in_rdy), 64'd1);
      chk("rst_req", 64'(req), 64'd0);
      chk("rst_level", 64'(level), 64'd0);
      chk("rst_err_cnt", 64'(err_cnt), 64'd0);

      // Single push and grant
      in_vld = 1'b1; in_dst = 2'd2; in_data = 32'hA5A5_0001;
      chk("push_same_cycle_req", 64'(req), 64'd0);
      tick();
      in_vld = 1'b0;
      chk("single_req", 64'(req), 64'b100);
      chk("single_data", 64'(out_data), 64'hA5A5_0001);
      vreq = 3'b100;
      tick();
      vreq = 3'b000;
      chk("single_pop_req", 64'(req), 64'd0);
      chk("single_pop_level", 64'(level), 64'd0);

      // Fill beyond depth
      for (int i = 0; i < 5; i++) begin
         in_vld = 1'b1; in_dst = 2'(i % 3); in_data = 32'h100 + 32'(i);
         tick();
      end
      chk("fill_level", 64'(level), 64'd4);
      chk("fill_in_rdy", 64'(in_rdy), 64'd0);
      chk("fill_head", 64'(out_data), 64'h100);
      vreq = 3'b001;
      tick();
      vreq = 3'b000;
      chk("fill_pop_level", 64'(level), 64'd3);
      chk("fill_pop_in_rdy", 64'(in_rdy), 64'd1);
      chk("fill_next_req", 64'(req), 64'b010);
      tick();
      in_vld = 1'b0;
      chk("fill_held_level", 64'(level), 64'd4);
      vreq = 3'b111;
      repeat (4) tick();
      vreq = 3'b000;
      chk("drain_level", 64'(level), 64'd0);

      // Streaming across several pointer wraps
      vreq = 3'b111;
      for (int i = 0; i < 30; i++) begin
         in_vld = 1'b1; in_dst = 2'(i % 3); in_data = 32'h2000 + 32'(i);
         tick();
         chk("stream_data", 64'(out_data), 64'h2000 + 64'(i));
         chk("stream_req", 64'(req), 64'(3'b001 << (i % 3)));
         chk("stream_level", 64'(level), 64'd1);
      end
      in_vld = 1'b0;
      tick();
      vreq = 3'b000;
      chk("stream_end_level", 64'(level), 64'd0);

      // Illegal destination
      in_vld = 1'b1; in_dst = 2'd3; in_data = 32'hDEAD_0005;
      tick();
      in_vld = 1'b0;
      chk("ill_err", 64'(err), 64'd1);
      chk("ill_cnt", 64'(err_cnt), 64'd1);
      chk("ill_req", 64'(req), 64'd0);
      chk("ill_level", 64'(level), 64'd0);
      tick();
      chk("ill_err_pulse", 64'(err), 64'd0);
      in_vld = 1'b1;
      repeat (300) tick();
      in_vld = 1'b0;
      tick();
      chk("ill_sat", 64'(err_cnt), 64'd255);

      // Stall with mismatching grant
      in_vld = 1'b1; in_dst = 2'd1; in_data = 32'hBEEF_0006;
      tick();
      in_vld = 1'b0;
      vreq = 3'b001;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("stall_req", 64'(req), 64'b010);
         chk("stall_data", 64'(out_data), 64'hBEEF_0006);
      end
      vreq = 3'b010;
      tick();
      vreq = 3'b000;
      chk("stall_pop_level", 64'(level), 64'd0);
      chk("stall_pop_req", 64'(req), 64'd0);

      // Asynchronous reset mid-stream
      for (int i = 0; i < 3; i++) begin
         in_vld = 1'b1; in_dst = 2'(i); in_data = 32'h300 + 32'(i);
         tick();
      end
      in_vld = 1'b0;
      chk("pre_rst_level", 64'(level), 64'd3);
      #3;
      rstn = 1'b0;
      #1;
      chk("arst_req", 64'(req), 64'd0);
      chk("arst_data", 64'(out_data), 64'd0);
      chk("arst_level", 64'(level), 64'd0);
      chk("arst_in_rdy", 64'(in_rdy), 64'd1);
      chk("arst_err_cnt", 64'(err_cnt), 64'd0);
      tick();
      rstn = 1'b1;
      repeat (2) tick();
      chk("post_rst_req", 64'(req), 64'd0);
      in_vld = 1'b1; in_dst = 2'd0; in_data = 32'h400;
      tick();
      in_vld = 1'b0;
      chk("post_rst_push_req", 64'(req), 64'b001);
      tick();
      run_cmp = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
